// File: rtl/rs_branch_pkg.sv
// rtl/rs_branch_pkg.sv - shared constants, entry type and tag helper for the branch reservation station
//
// Purpose: widths reused from the core headers, station geometry, the stored
// entry layout, and the CDB tag-match helper used by the operand wakeup logic.
// Ports: none (package).

package rs_branch_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ADDR_LEN     = 32;
  localparam int ALU_OP_WIDTH = 4;
  localparam int OPCODE_LEN   = 7;

  localparam int RS_BRANCH_ENTRY_NUM = 4;
  localparam int RS_BRANCH_ENTRY_SEL = 2;
  localparam int RRF_TAG_LEN         = 6;

  typedef struct packed {
    logic                    valid;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [OPCODE_LEN-1:0]   opcode;
    logic [ADDR_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     imm;
    logic [DATA_LEN-1:0]     src1;
    logic                    src1_valid;
    logic [DATA_LEN-1:0]     src2;
    logic                    src2_valid;
    logic [RRF_TAG_LEN-1:0]  rrftag;
    logic                    write_rrf;
  } rs_branch_entry_t;

  // A waiting operand keeps its producer tag in the low bits of the src field.
  function automatic logic tag_match(input logic                   cdb_valid,
                                     input logic [RRF_TAG_LEN-1:0] cdb_tag,
                                     input logic [RRF_TAG_LEN-1:0] src_tag);
    return cdb_valid && (cdb_tag == src_tag);
  endfunction

endpackage

// File: rtl/rs_branch_if.sv
// rtl/rs_branch_if.sv - dispatch, CDB, issue and status bundle of the branch reservation station
//
// Purpose: groups every non-clock/reset signal of rs_branch.
// Modports:
//   master - upstream side: drives kill, dispatch fields and both CDB ports;
//            observes issue, head fields, full and count.
//   slave  - the reservation station itself.

interface rs_branch_if;
  import rs_branch_pkg::*;

  logic                       kill_i;

  logic                       dispatch_we_i;
  logic [ALU_OP_WIDTH-1:0]    alu_op_i;
  logic [OPCODE_LEN-1:0]      opcode_i;
  logic [ADDR_LEN-1:0]        pc_i;
  logic [DATA_LEN-1:0]        imm_i;
  logic [DATA_LEN-1:0]        src1_i;
  logic [DATA_LEN-1:0]        src2_i;
  logic                       src1_valid_i;
  logic                       src2_valid_i;
  logic [RRF_TAG_LEN-1:0]     rrftag_i;
  logic                       write_rrf_i;

  logic                       cdb1_valid_i;
  logic [RRF_TAG_LEN-1:0]     cdb1_tag_i;
  logic [DATA_LEN-1:0]        cdb1_data_i;
  logic                       cdb2_valid_i;
  logic [RRF_TAG_LEN-1:0]     cdb2_tag_i;
  logic [DATA_LEN-1:0]        cdb2_data_i;

  logic                       issue_o;
  logic [ALU_OP_WIDTH-1:0]    ex_alu_op_o;
  logic [OPCODE_LEN-1:0]      ex_opcode_o;
  logic [ADDR_LEN-1:0]        ex_pc_o;
  logic [DATA_LEN-1:0]        ex_imm_o;
  logic [DATA_LEN-1:0]        ex_src1_o;
  logic [DATA_LEN-1:0]        ex_src2_o;
  logic [RRF_TAG_LEN-1:0]     ex_rrftag_o;
  logic                       ex_write_rrf_o;

  logic                       full_o;
  logic [RS_BRANCH_ENTRY_SEL:0] count_o;

  modport master (
    output kill_i, dispatch_we_i, alu_op_i, opcode_i, pc_i, imm_i,
           src1_i, src2_i, src1_valid_i, src2_valid_i, rrftag_i, write_rrf_i,
           cdb1_valid_i, cdb1_tag_i, cdb1_data_i,
           cdb2_valid_i, cdb2_tag_i, cdb2_data_i,
    input  issue_o, ex_alu_op_o, ex_opcode_o, ex_pc_o, ex_imm_o,
           ex_src1_o, ex_src2_o, ex_rrftag_o, ex_write_rrf_o,
           full_o, count_o
  );

  modport slave (
    input  kill_i, dispatch_we_i, alu_op_i, opcode_i, pc_i, imm_i,
           src1_i, src2_i, src1_valid_i, src2_valid_i, rrftag_i, write_rrf_i,
           cdb1_valid_i, cdb1_tag_i, cdb1_data_i,
           cdb2_valid_i, cdb2_tag_i, cdb2_data_i,
    output issue_o, ex_alu_op_o, ex_opcode_o, ex_pc_o, ex_imm_o,
           ex_src1_o, ex_src2_o, ex_rrftag_o, ex_write_rrf_o,
           full_o, count_o
  );

endinterface

// File: rtl/rs_branch_src_operand_wakeup.sv
// rtl/rs_branch_src_operand_wakeup.sv - one source operand's CDB capture logic
//
// Purpose: given a stored (or incoming) operand and both CDB ports, produce the
// operand value/valid for the next cycle. Port 1 wins when both ports carry the
// operand's tag.
// Ports:
//   src, src_valid             - current operand value (or tag) and valid flag
//   cdb1_valid/tag/data        - CDB port 1
//   cdb2_valid/tag/data        - CDB port 2
//   next_src, next_src_valid   - operand after capture

module src_operand_wakeup
  import rs_branch_pkg::*;
(
  input  logic [DATA_LEN-1:0]    src,
  input  logic                   src_valid,
  input  logic                   cdb1_valid,
  input  logic [RRF_TAG_LEN-1:0] cdb1_tag,
  input  logic [DATA_LEN-1:0]    cdb1_data,
  input  logic                   cdb2_valid,
  input  logic [RRF_TAG_LEN-1:0] cdb2_tag,
  input  logic [DATA_LEN-1:0]    cdb2_data,
  output logic [DATA_LEN-1:0]    next_src,
  output logic                   next_src_valid
);

  always_comb begin
    next_src       = src;
    next_src_valid = src_valid;
    if (!src_valid) begin
      if (tag_match(cdb1_valid, cdb1_tag, src[RRF_TAG_LEN-1:0])) begin
        next_src       = cdb1_data;
        next_src_valid = 1'b1;
      end else if (tag_match(cdb2_valid, cdb2_tag, src[RRF_TAG_LEN-1:0])) begin
        next_src       = cdb2_data;
        next_src_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_branch.sv
// rtl/rs_branch.sv - in-order reservation station for the branch pipe
//
// Purpose: circular buffer of RS_BRANCH_ENTRY_NUM branch/jump ops between
// dispatch and the branch unit. Missing operands are captured from two CDB
// ports; only the oldest op may issue, at most one per cycle.
// Ports:
//   clk_i        - clock
//   reset_i      - synchronous active-high reset
//   rs           - rs_branch_if.slave: kill, dispatch, CDB, issue, status
//   stall_cnt_o  - cycles with a valid but unready head (only when
//                  RS_BRANCH_STALL_CNT_EN is defined)
// Optional feature macro: RS_BRANCH_STALL_CNT_EN

module rs_branch
  import rs_branch_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  rs_branch_if.slave  rs
`ifdef RS_BRANCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int N   = RS_BRANCH_ENTRY_NUM;
  localparam int SEL = RS_BRANCH_ENTRY_SEL;
  localparam logic [SEL:0]   FULL_COUNT = N[SEL:0];
  localparam logic [SEL:0]   COUNT_ONE  = 1;
  localparam logic [SEL-1:0] PTR_ONE    = 1;

  rs_branch_entry_t ent_q [N];
  logic [SEL-1:0]   head_q;
  logic [SEL-1:0]   tail_q;
  logic [SEL:0]     count_q;

  logic [DATA_LEN-1:0] wk_src1       [N];
  logic                wk_src1_valid [N];
  logic [DATA_LEN-1:0] wk_src2       [N];
  logic                wk_src2_valid [N];

  rs_branch_entry_t head_ent;
  rs_branch_entry_t disp_ent;
  logic             head_ops_ready;
  logic             full;
  logic             issue;
  logic             dispatch_acc;

  // Per-entry wakeup: runs on every entry, results only committed for valid ones.
  for (genvar i = 0; i < N; i++) begin : g_wake
    src_operand_wakeup u_wake_src1 (
      .src            (ent_q[i].src1),
      .src_valid      (ent_q[i].src1_valid),
      .cdb1_valid     (rs.cdb1_valid_i),
      .cdb1_tag       (rs.cdb1_tag_i),
      .cdb1_data      (rs.cdb1_data_i),
      .cdb2_valid     (rs.cdb2_valid_i),
      .cdb2_tag       (rs.cdb2_tag_i),
      .cdb2_data      (rs.cdb2_data_i),
      .next_src       (wk_src1[i]),
      .next_src_valid (wk_src1_valid[i])
    );
    src_operand_wakeup u_wake_src2 (
      .src            (ent_q[i].src2),
      .src_valid      (ent_q[i].src2_valid),
      .cdb1_valid     (rs.cdb1_valid_i),
      .cdb1_tag       (rs.cdb1_tag_i),
      .cdb1_data      (rs.cdb1_data_i),
      .cdb2_valid     (rs.cdb2_valid_i),
      .cdb2_tag       (rs.cdb2_tag_i),
      .cdb2_data      (rs.cdb2_data_i),
      .next_src       (wk_src2[i]),
      .next_src_valid (wk_src2_valid[i])
    );
  end

  // Dispatch-cycle bypass so an op whose producer broadcasts this cycle
  // is stored already ready.
  logic [DATA_LEN-1:0] disp_src1;
  logic                disp_src1_valid;
  logic [DATA_LEN-1:0] disp_src2;
  logic                disp_src2_valid;

  src_operand_wakeup u_disp_src1 (
    .src            (rs.src1_i),
    .src_valid      (rs.src1_valid_i),
    .cdb1_valid     (rs.cdb1_valid_i),
    .cdb1_tag       (rs.cdb1_tag_i),
    .cdb1_data      (rs.cdb1_data_i),
    .cdb2_valid     (rs.cdb2_valid_i),
    .cdb2_tag       (rs.cdb2_tag_i),
    .cdb2_data      (rs.cdb2_data_i),
    .next_src       (disp_src1),
    .next_src_valid (disp_src1_valid)
  );

  src_operand_wakeup u_disp_src2 (
    .src            (rs.src2_i),
    .src_valid      (rs.src2_valid_i),
    .cdb1_valid     (rs.cdb1_valid_i),
    .cdb1_tag       (rs.cdb1_tag_i),
    .cdb1_data      (rs.cdb1_data_i),
    .cdb2_valid     (rs.cdb2_valid_i),
    .cdb2_tag       (rs.cdb2_tag_i),
    .cdb2_data      (rs.cdb2_data_i),
    .next_src       (disp_src2),
    .next_src_valid (disp_src2_valid)
  );

  always_comb begin
    disp_ent            = '0;
    disp_ent.valid      = 1'b1;
    disp_ent.alu_op     = rs.alu_op_i;
    disp_ent.opcode     = rs.opcode_i;
    disp_ent.pc         = rs.pc_i;
    disp_ent.imm        = rs.imm_i;
    disp_ent.src1       = disp_src1;
    disp_ent.src1_valid = disp_src1_valid;
    disp_ent.src2       = disp_src2;
    disp_ent.src2_valid = disp_src2_valid;
    disp_ent.rrftag     = rs.rrftag_i;
    disp_ent.write_rrf  = rs.write_rrf_i;
  end

  assign head_ent       = ent_q[head_q];
  assign head_ops_ready = head_ent.src1_valid & head_ent.src2_valid;
  assign full           = (count_q == FULL_COUNT);

  // Readiness comes from stored state only; a same-cycle CDB hit on the head
  // lands in the entry and issues next cycle. Reset acts as a kill.
  assign issue        = head_ent.valid & head_ops_ready & ~rs.kill_i & ~reset_i;
  // full is the start-of-cycle count, so a simultaneous issue never frees a slot.
  assign dispatch_acc = rs.dispatch_we_i & ~full & ~rs.kill_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || rs.kill_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ent_q[i].valid) begin
          ent_q[i].src1       <= wk_src1[i];
          ent_q[i].src1_valid <= wk_src1_valid[i];
          ent_q[i].src2       <= wk_src2[i];
          ent_q[i].src2_valid <= wk_src2_valid[i];
        end
      end
      if (issue) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PTR_ONE;
      end
      // Tail only equals head when empty or full, so this never collides
      // with the issue write above.
      if (dispatch_acc) begin
        ent_q[tail_q] <= disp_ent;
        tail_q        <= tail_q + PTR_ONE;
      end
      case ({dispatch_acc, issue})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rs.issue_o        = issue;
  assign rs.ex_alu_op_o    = head_ent.alu_op;
  assign rs.ex_opcode_o    = head_ent.opcode;
  assign rs.ex_pc_o        = head_ent.pc;
  assign rs.ex_imm_o       = head_ent.imm;
  assign rs.ex_src1_o      = head_ent.src1;
  assign rs.ex_src2_o      = head_ent.src2;
  assign rs.ex_rrftag_o    = head_ent.rrftag;
  assign rs.ex_write_rrf_o = head_ent.write_rrf;
  assign rs.full_o         = full;
  assign rs.count_o        = count_q;

`ifdef RS_BRANCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Survives kill on purpose: it measures stalls across flushes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if (head_ent.valid && !head_ops_ready && !rs.kill_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_branch.sv
// tb/tb_rs_branch.sv - self-checking bench for rs_branch with a queue reference model

module tb_rs_branch;
  import rs_branch_pkg::*;

  typedef struct {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [OPCODE_LEN-1:0]   opcode;
    logic [ADDR_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     imm;
    logic [DATA_LEN-1:0]     s1;
    logic                    s1v;
    logic [DATA_LEN-1:0]     s2;
    logic                    s2v;
    logic [RRF_TAG_LEN-1:0]  tag;
    logic                    wr;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rs_branch_if bus();

`ifdef RS_BRANCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  rs_branch dut (.clk_i(clk), .reset_i(reset), .rs(bus), .stall_cnt_o(stall_cnt));
`else
  rs_branch dut (.clk_i(clk), .reset_i(reset), .rs(bus));
`endif

  int  checks = 0;
  int  failures = 0;
  op_t q[$];
  bit  model_live = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.kill_i        = 1'b0;
    bus.dispatch_we_i = 1'b0;
    bus.alu_op_i      = '0;
    bus.opcode_i      = '0;
    bus.pc_i          = '0;
    bus.imm_i         = '0;
    bus.src1_i        = '0;
    bus.src2_i        = '0;
    bus.src1_valid_i  = 1'b0;
    bus.src2_valid_i  = 1'b0;
    bus.rrftag_i      = '0;
    bus.write_rrf_i   = 1'b0;
    bus.cdb1_valid_i  = 1'b0;
    bus.cdb1_tag_i    = '0;
    bus.cdb1_data_i   = '0;
    bus.cdb2_valid_i  = 1'b0;
    bus.cdb2_tag_i    = '0;
    bus.cdb2_data_i   = '0;
  endtask

  task automatic drive(input logic [ADDR_LEN-1:0] pc,
                       input logic [DATA_LEN-1:0] s1, input logic s1v,
                       input logic [DATA_LEN-1:0] s2, input logic s2v);
    bus.dispatch_we_i = 1'b1;
    bus.alu_op_i      = pc[5:2];
    bus.opcode_i      = 7'b1100011;
    bus.pc_i          = pc;
    bus.imm_i         = 32'd8;
    bus.src1_i        = s1;
    bus.src1_valid_i  = s1v;
    bus.src2_i        = s2;
    bus.src2_valid_i  = s2v;
    bus.rrftag_i      = pc[7:2];
    bus.write_rrf_i   = pc[2];
  endtask

  // An operand still waiting takes the broadcast data; port 1 is preferred.
  function automatic logic [DATA_LEN:0] wake(input logic [DATA_LEN-1:0] v, input logic vld);
    if (vld) return {1'b1, v};
    if (bus.cdb1_valid_i && bus.cdb1_tag_i == v[RRF_TAG_LEN-1:0]) return {1'b1, bus.cdb1_data_i};
    if (bus.cdb2_valid_i && bus.cdb2_tag_i == v[RRF_TAG_LEN-1:0]) return {1'b1, bus.cdb2_data_i};
    return {1'b0, v};
  endfunction

  function automatic void model_step(input bit iss);
    int  sz;
    op_t e;
    sz = q.size();
    if (reset || bus.kill_i) begin
      q.delete();
      return;
    end
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      {e.s1v, e.s1} = wake(e.s1, e.s1v);
      {e.s2v, e.s2} = wake(e.s2, e.s2v);
      q[i] = e;
    end
    if (iss) void'(q.pop_front());
    if (bus.dispatch_we_i && sz < RS_BRANCH_ENTRY_NUM) begin
      e.alu_op = bus.alu_op_i;
      e.opcode = bus.opcode_i;
      e.pc     = bus.pc_i;
      e.imm    = bus.imm_i;
      {e.s1v, e.s1} = wake(bus.src1_i, bus.src1_valid_i);
      {e.s2v, e.s2} = wake(bus.src2_i, bus.src2_valid_i);
      e.tag    = bus.rrftag_i;
      e.wr     = bus.write_rrf_i;
      q.push_back(e);
    end
  endfunction

  // One clock: compare at the falling edge, advance the model, then return
  // just after the rising edge with inputs back to idle.
  task automatic cycle();
    bit exp_issue;
    @(negedge clk);
    exp_issue = !reset && !bus.kill_i && q.size() > 0 && q[0].s1v && q[0].s2v;
    if (model_live) begin
      chk("issue", bus.issue_o, exp_issue);
      chk("count", bus.count_o, q.size());
      chk("full", bus.full_o, q.size() == RS_BRANCH_ENTRY_NUM);
      if (q.size() > 0) begin
        chk("ex_alu_op", bus.ex_alu_op_o, q[0].alu_op);
        chk("ex_opcode", bus.ex_opcode_o, q[0].opcode);
        chk("ex_pc", bus.ex_pc_o, q[0].pc);
        chk("ex_imm", bus.ex_imm_o, q[0].imm);
        chk("ex_src1", bus.ex_src1_o, q[0].s1);
        chk("ex_src2", bus.ex_src2_o, q[0].s2);
        chk("ex_rrftag", bus.ex_rrftag_o, q[0].tag);
        chk("ex_write_rrf", bus.ex_write_rrf_o, q[0].wr);
      end
    end
    model_step(exp_issue);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    model_live = 1;
    chk("reset_count", bus.count_o, 0);
    chk("reset_full", bus.full_o, 0);
    chk("reset_issue", bus.issue_o, 0);
    chk("reset_ex_pc", bus.ex_pc_o, 0);

    // BEQ with both operands ready
    drive(32'h100, 32'd5, 1'b1, 32'd5, 1'b1);
    cycle();
    chk("beq_issue", bus.issue_o, 1);
    chk("beq_pc", bus.ex_pc_o, 32'h100);
    cycle();
    chk("beq_count", bus.count_o, 0);

    // src1 waits on tag 3, broadcast on cdb2 two cycles after dispatch
    drive(32'h200, 32'd3, 1'b0, 32'd9, 1'b1);
    cycle();
    chk("t2_wait0", bus.issue_o, 0);
    cycle();
    chk("t2_wait1", bus.issue_o, 0);
    bus.cdb2_valid_i = 1'b1;
    bus.cdb2_tag_i   = 6'd3;
    bus.cdb2_data_i  = 32'h2A;
    #1;
    chk("t2_bcast_cycle", bus.issue_o, 0);
    cycle();
    chk("t2_issue", bus.issue_o, 1);
    chk("t2_src1", bus.ex_src1_o, 32'h2A);
    cycle();

    // dispatch-cycle bypass from cdb1
    drive(32'h300, 32'd1, 1'b1, 32'd7, 1'b0);
    bus.cdb1_valid_i = 1'b1;
    bus.cdb1_tag_i   = 6'd7;
    bus.cdb1_data_i  = 32'h11;
    cycle();
    chk("t3_issue", bus.issue_o, 1);
    chk("t3_src2", bus.ex_src2_o, 32'h11);
    cycle();

    // fill with a stalled head, younger ones ready
    drive(32'h0, 32'd9, 1'b0, 32'd1, 1'b1);  cycle();
    drive(32'h4, 32'd1, 1'b1, 32'd1, 1'b1);  cycle();
    drive(32'h8, 32'd1, 1'b1, 32'd1, 1'b1);  cycle();
    chk("t4_no_bypass", bus.issue_o, 0);
    drive(32'hC, 32'd1, 1'b1, 32'd1, 1'b1);  cycle();
    chk("t4_full", bus.full_o, 1);
    chk("t4_count4", bus.count_o, 4);
    drive(32'h10, 32'd1, 1'b1, 32'd1, 1'b1); cycle();
    chk("t4_ignored", bus.count_o, 4);
    chk("t4_head_pc", bus.ex_pc_o, 32'h0);
    bus.cdb1_valid_i = 1'b1;
    bus.cdb1_tag_i   = 6'd9;
    bus.cdb1_data_i  = 32'h55;
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("t4_order_issue", bus.issue_o, 1);
      chk("t4_order_pc", bus.ex_pc_o, 32'(k * 4));
      cycle();
    end
    chk("t4_drained", bus.count_o, 0);
    drive(32'h40, 32'd1, 1'b1, 32'd1, 1'b1); cycle();
    drive(32'h44, 32'd1, 1'b1, 32'd1, 1'b1); cycle();
    cycle();
    chk("t4_refill_drained", bus.count_o, 0);

    // kill with dispatch while three ready entries are held
    drive(32'h50, 32'd20, 1'b0, 32'd1, 1'b1); cycle();
    drive(32'h54, 32'd20, 1'b0, 32'd1, 1'b1); cycle();
    drive(32'h58, 32'd20, 1'b0, 32'd1, 1'b1); cycle();
    bus.cdb1_valid_i = 1'b1;
    bus.cdb1_tag_i   = 6'd20;
    bus.cdb1_data_i  = 32'h77;
    cycle();
    chk("t5_head_ready", bus.issue_o, 1);
    drive(32'h5C, 32'd1, 1'b1, 32'd1, 1'b1);
    bus.kill_i = 1'b1;
    #1;
    chk("t5_kill_issue", bus.issue_o, 0);
    cycle();
    chk("t5_count", bus.count_o, 0);
    chk("t5_issue_after", bus.issue_o, 0);

`ifdef RS_BRANCH_STALL_CNT_EN
    begin
      logic [31:0] s0;
      drive(32'h60, 32'd30, 1'b0, 32'd1, 1'b1);
      cycle();
      s0 = stall_cnt;
      repeat (6) cycle();
      chk("stall_cnt_delta", stall_cnt - s0, 6);
      bus.cdb1_valid_i = 1'b1;
      bus.cdb1_tag_i   = 6'd30;
      bus.cdb1_data_i  = 32'h1;
      cycle();
      cycle();
    end
`endif

    // randomized traffic against the queue model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 60) begin
        drive($urandom & 32'hFFFF_FFFC,
              ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 55),
              ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 55));
        bus.imm_i = $urandom;
      end
      bus.cdb1_valid_i = 1'($urandom_range(0, 1));
      bus.cdb1_tag_i   = 6'($urandom_range(0, 7));
      bus.cdb1_data_i  = $urandom;
      bus.cdb2_valid_i = 1'($urandom_range(0, 1));
      bus.cdb2_tag_i   = 6'($urandom_range(0, 7));
      bus.cdb2_data_i  = $urandom;
      bus.kill_i       = ($urandom_range(0, 39) == 0);
      reset            = ($urandom_range(0, 399) == 0);
      cycle();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_branch.md
Name: rs_branch

Overview:
- Reservation station for the branch pipe.
- Sits between dispatch and the branch execution unit (ALU comparator plus target calculation).
- Buffers up to ENTRY_NUM branch/jump ops and captures missing operands from two CDB broadcast ports.
- Issues strictly in program order, at most one op per cycle, to the branch unit. In-order issue keeps speculative branch tags ordered for the ROB.

Parameters:
- ENTRY_NUM, 4, number of entries; power of two, ≥2.
- ENTRY_SEL, 2, log2(ENTRY_NUM); width of head/tail pointers.
- RRF_TAG_LEN, 6, width of a rename-register tag.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- kill_i  in  1  mispredict flush; empties the station
- dispatch_we_i  in  1  write one op at tail
- alu_op_i  in  ALU_OP_WIDTH  comparator op
- opcode_i  in  OPCODE_LEN  RV32 opcode
- pc_i  in  ADDR_LEN  instruction PC
- imm_i  in  DATA_LEN  sign-extended offset
- src1_i, src2_i  in  DATA_LEN  operand value, or RRF tag in the low RRF_TAG_LEN bits when not valid
- src1_valid_i, src2_valid_i  in  1  operand holds data
- rrftag_i  in  RRF_TAG_LEN  destination tag
- write_rrf_i  in  1  op writes rd
- cdb1_valid_i, cdb2_valid_i  in  1  broadcast valid
- cdb1_tag_i, cdb2_tag_i  in  RRF_TAG_LEN  broadcast tag
- cdb1_data_i, cdb2_data_i  in  DATA_LEN  broadcast data
- issue_o  out  1  head issued this cycle (drives branch unit issue_i)
- ex_alu_op_o, ex_opcode_o, ex_pc_o, ex_imm_o, ex_src1_o, ex_src2_o, ex_rrftag_o, ex_write_rrf_o  out  as inputs  head fields
- full_o  out  1  count == ENTRY_NUM
- count_o  out  ENTRY_SEL+1  occupied entries

Behaviour:
- Storage is a circular buffer with head/tail pointers and a count.
- Reset: head = tail = 0, count = 0, all entry valid bits 0. issue_o = 0, full_o = 0, count_o = 0. ex_* fields are don't-care but must not be X-propagating; clear them to 0.
- Dispatch:
  - When dispatch_we_i & ~full_o & ~kill_i, the op is written at tail and tail increments, wrapping modulo ENTRY_NUM.
  - Dispatch while full_o is ignored. This holds even if an issue happens the same cycle, because full_o reflects the start-of-cycle count. Upstream must stall on full_o.
- Dispatch-cycle bypass: if an incoming srcN_valid_i = 0 and cdbK_valid_i matches its tag in that cycle, write cdbK_data_i with valid = 1.
- Wakeup: every valid entry with srcN not valid compares against both CDB ports each cycle. On a match it captures the data and sets valid the next cycle. If both ports match the same tag, port 1 wins.
- Issue:
  - issue_o = head_valid & src1_ready & src2_ready & ~kill_i, combinational from stored state. A same-cycle CDB hit does not make the head issuable; it issues the following cycle.
  - ex_* are driven combinationally from the head entry.
  - On issue, head increments and the entry is invalidated at the clock edge.
- Younger ready entries never bypass a stalled head.
- Count: next = count + dispatch_accepted − issue_o. Simultaneous dispatch and issue leaves count unchanged.
- Flush:
  - kill_i takes priority over dispatch, wakeup and issue.
  - Next cycle count = 0 and head = tail = 0.
  - issue_o is forced 0 during the kill cycle.
- Reset asserted mid-operation behaves exactly as kill_i plus reset values.
- Tag compare uses the low RRF_TAG_LEN bits of the stored src field.

Optional Feature:
- Macro: RS_BRANCH_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt_o, 32 bits.
  - It counts cycles where the head is valid and not ready, with no kill.
  - Saturates at 0xFFFFFFFF; cleared by reset only.
- Without it: the port and the counter are absent; no other behaviour changes.

Decomposition:
- Shared consts header: RS_BRANCH_ENTRY_NUM, RS_BRANCH_ENTRY_SEL, RRF_TAG_LEN. DATA_LEN, ADDR_LEN, ALU_OP_WIDTH and OPCODE_LEN are reused from the existing headers.
- One sub-module, src_operand_wakeup. It is instantiated twice per entry and once per operand on the dispatch path.
  - Inputs: stored value/valid, both CDB ports.
  - Outputs: next value/valid.
  - Carries the port-1 priority rule.

Test Plan:
- Reset, then dispatch a BEQ with PC 0x100, imm 8, both srcs valid (5, 5): issue_o = 1 the next cycle with ex_pc_o = 0x100, and count returns to 0 the cycle after.
- Dispatch a branch with src1 tag 3 not valid, then drive cdb2 tag 3 data 0x2A two cycles later: issue_o stays 0 until the cycle after the broadcast, then ex_src1_o = 0x2A.
- Dispatch with src2 tag 7 while cdb1 broadcasts tag 7 data 0x11 in the same cycle: the entry is ready and issues the next cycle with ex_src2_o = 0x11.
- Fill 4 entries with the head not ready: full_o = 1, a 5th dispatch is ignored, and a ready entry 2 does not issue before the head. Wake the head: issue order is PCs 0x0, 0x4, 0x8, 0xC, and tail wraps correctly on refill.
- With 3 entries valid, assert kill_i together with dispatch_we_i: issue_o = 0 that cycle, and the next cycle count_o = 0 with no entry issued.
- With RS_BRANCH_STALL_CNT_EN defined, hold the head unready for 6 cycles: stall_cnt_o = 6.
